// File: rtl/lcd_pll_ctrl.sv
// Reset, divider-code and lock-supervision sequencer for the LCD pixel-clock rPLL.
// Define LCD_PLL_CTRL_AUTO_RELOCK_EN to restart the PLL on lock loss in RUN instead of erroring.
module lcd_pll_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [5:0]  INIT_IDSEL   = 6'd0,
    parameter logic [5:0]  INIT_FBDSEL  = 6'd0,
    parameter logic [5:0]  INIT_ODSEL   = 6'd0
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       pix_rst,
    output logic       ready,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] RstLast     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] StableLast  = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  RetryMax    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StRst,
        StWaitLock,
        StStable,
        StRun,
        StError
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d, timer_inc;
    logic [3:0]  retry_q, retry_d;
    logic        lock_meta, lock_s;
    logic        cfg_accept;
    logic [5:0]  idsel_d, fbdsel_d, odsel_d;
    logic        err_d, pll_reset_d, ready_d, cfg_ready_d, done_d;

    assign cfg_accept = cfg_valid & cfg_ready;
    // One timer serves the reset pulse, the lock timeout and the stability window.
    assign timer_inc  = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_inc;
        retry_d  = retry_q;
        idsel_d  = pll_idsel;
        fbdsel_d = pll_fbdsel;
        odsel_d  = pll_odsel;
        err_d    = err;

        case (state_q)
            StRst: begin
                if (timer_q == RstLast) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                    timer_d = '0;
                end else if (timer_q == TimeoutLast) begin
                    timer_d = '0;
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + 4'd1;
                        state_d = StRst;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                    retry_d = '0;
                    timer_d = '0;
                end
            end
            StRun: begin
                // A new configuration takes priority over a simultaneous lock loss.
                if (cfg_accept) begin
                    idsel_d  = cfg_idsel;
                    fbdsel_d = cfg_fbdsel;
                    odsel_d  = cfg_odsel;
                    err_d    = 1'b0;
                    state_d  = StRst;
                    timer_d  = '0;
                end else if (!lock_s) begin
`ifdef LCD_PLL_CTRL_AUTO_RELOCK_EN
                    state_d = StRst;
                    retry_d = '0;
                    timer_d = '0;
`else
                    state_d = StError;
`endif
                end
            end
            StError: begin
                if (cfg_accept) begin
                    idsel_d  = cfg_idsel;
                    fbdsel_d = cfg_fbdsel;
                    odsel_d  = cfg_odsel;
                    err_d    = 1'b0;
                    retry_d  = '0;
                    state_d  = StRst;
                    timer_d  = '0;
                end
            end
            default: begin
                state_d = StRst;
                timer_d = '0;
            end
        endcase

        if (state_d == StError) begin
            err_d = 1'b1;
        end

        pll_reset_d = (state_d == StRst) || (state_d == StError);
        ready_d     = (state_d == StRun);
        cfg_ready_d = (state_d == StRun) || (state_d == StError);
        done_d      = (state_d == StRun) && (state_q != StRun);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= StRst;
            timer_q    <= '0;
            retry_q    <= '0;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            pll_reset  <= 1'b1;
            pll_idsel  <= INIT_IDSEL;
            pll_fbdsel <= INIT_FBDSEL;
            pll_odsel  <= INIT_ODSEL;
            pix_rst    <= 1'b1;
            ready      <= 1'b0;
            cfg_ready  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            lock_meta  <= pll_lock;
            lock_s     <= lock_meta;
            pll_reset  <= pll_reset_d;
            pll_idsel  <= idsel_d;
            pll_fbdsel <= fbdsel_d;
            pll_odsel  <= odsel_d;
            pix_rst    <= ~ready_d;
            ready      <= ready_d;
            cfg_ready  <= cfg_ready_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/lcd_pll_ctrl.md
# lcd_pll_ctrl

Sequencing controller for the LCD pixel-clock rPLL. Runs on the PLL reference clock. Holds the PLL in reset for a fixed pulse and drives its dynamic IDSEL/FBDSEL/ODSEL divider codes. It supervises LOCK with a timeout and bounded retries, and releases the pixel-domain reset only after lock has been stable. Sits between the board reference clock and the lcd_pll instance; the LCD timing generator consumes `pix_rst`.

## Interface
- `RST_CYCLES`, 16: PLL reset pulse width, clkin cycles (1..255)
- `LOCK_TIMEOUT`, 65535: max clkin cycles waiting for lock per attempt (1..65535)
- `LOCK_STABLE`, 256: consecutive synced-lock cycles required before release (1..65535)
- `MAX_RETRY`, 3: extra reset attempts after a timeout before ERROR (0..15)
- `INIT_IDSEL`, `INIT_FBDSEL`, `INIT_ODSEL`, 6'd0: divider codes after reset; the same encoding the rPLL dynamic inputs expect

- `clkin` in 1: reference clock; the only clock
- `reset` in 1: synchronous, active-high
- `cfg_valid` in 1: new divider set offered
- `cfg_ready` out 1: controller accepts a set; transfer on `cfg_valid & cfg_ready`
- `cfg_idsel`, `cfg_fbdsel`, `cfg_odsel` in 6 each: requested codes
- `pll_lock` in 1: rPLL LOCK, asynchronous; 2-FF synchronised internally (`lock_s`)
- `pll_reset` out 1: to rPLL RESET
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: to rPLL IDSEL/FBDSEL/ODSEL
- `pix_rst` out 1: active-high reset for the pixel domain
- `ready` out 1: PLL locked and stable
- `done` out 1: one-cycle pulse on every entry to RUN
- `err` out 1: sticky failure flag

## Operation
- Reset values: state RST, `pll_reset`=1, `pll_*sel`=INIT_*, `pix_rst`=1, `ready`=0, `cfg_ready`=0, `done`=0, `err`=0, retry count=0, sync flops=0.
- RST: `pll_reset`=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with `pll_reset`=0 and the timer cleared.
- WAIT_LOCK: if `lock_s`=1, go to STABLE with the stable counter at 0.
  - If the timer reaches LOCK_TIMEOUT and retry count < MAX_RETRY: increment the count and go to RST.
  - Otherwise go to ERROR.
- STABLE: if `lock_s`=0, go to WAIT_LOCK with the timer cleared; the retry count is kept.
  - After LOCK_STABLE consecutive high cycles, go to RUN and clear the retry count.
- RUN: `ready`=1, `pix_rst`=0, `cfg_ready`=1.
  - An accepted cfg latches the codes into `pll_*sel`, clears `err` and goes to RST.
  - If `lock_s` falls: see Configuration.
- ERROR: `err`=1, `pll_reset`=1, `pix_rst`=1, `ready`=0, `cfg_ready`=1.
  - An accepted cfg latches the codes, clears `err` and the retry count, and goes to RST.
- `cfg_ready` is high only in RUN and ERROR.
- `pll_*sel` change only on an accepted cfg or on `reset`, so the codes are always stable while `pll_reset` is low.
- In RUN, an accepted cfg and a `lock_s` fall in the same cycle: the cfg wins.
- `reset` mid-sequence: all state returns to reset values and the codes revert to INIT_*.
- Counters are 16-bit and saturating; the retry count is 4-bit.

## Timing
- All outputs are registered; the state transition and the output change occur on the same clkin edge.
- Lock synchroniser latency is 2 cycles: a `pll_lock` rise at edge N is seen as `lock_s` at edge N+2.
- First `pll_reset` deassertion is at edge RST_CYCLES after `reset` falls.
- Lock to release: `ready`/`pix_rst`/`done` change LOCK_STABLE cycles after `lock_s` rises, i.e. 2+LOCK_STABLE cycles after the `pll_lock` rise.
- The timeout fires at the LOCK_TIMEOUT-th WAIT_LOCK cycle.
- Accepted cfg to `pll_reset`=1 and new codes: 1 cycle; `ready`/`cfg_ready` drop on that same edge.

## Configuration
- `LCD_PLL_CTRL_AUTO_RELOCK_EN` defined: a `lock_s` fall in RUN goes to RST with the current codes and a cleared retry count; `err` is unchanged.
- Not defined: a `lock_s` fall in RUN goes to ERROR.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRY=2.
- Reset release, `pll_lock` rises 20 cycles later -> `pll_reset` low at cycle 4; `ready`=1, `pix_rst`=0 and a single `done` pulse 10 cycles after the lock rise; codes = INIT_*.
- `pll_lock` held 0 -> three `pll_reset` pulses of 4 cycles, each followed by 100 wait cycles; then `err`=1, `cfg_ready`=1, `pll_reset`=1.
- In RUN, `cfg_valid` with codes 3/24/4 -> accepted in 1 cycle, `pll_*sel`=3/24/4, `ready`=0, `pll_reset`=1 for 4 cycles, re-lock gives `done`.
- Lock glitch: `pll_lock` low for 3 cycles at STABLE cycle 5 -> `ready` held 0; after `lock_s` is high again, release occurs after 8 consecutive stable cycles.
- In RUN, drop `pll_lock` -> with the macro: RST with unchanged codes, then re-lock; without the macro: ERROR with `err`=1. Same-cycle cfg plus lock loss -> new codes taken, `err`=0.
- `reset` asserted mid-WAIT_LOCK after a cfg of 5/10/2 -> codes return to INIT_*, `err`=0, RST sequence restarts.
